// File: rtl/alu_req_arbiter.sv
// Two-requester round-robin front end for a single shared 32-bit ALU.
// It accepts one request at a time, runs the ALU start/done sequence with a timeout, and returns the result.
module alu_req_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,

  // Handshake rule for every channel here: a transfer happens on a rising edge
  // where valid && ready. The sender holds valid and its payload until that edge.
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [1:0]  req0_op,
  input  logic [4:0]  req0_cfg,
  input  logic        req0_cin,
  input  logic        req0_bin,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [1:0]  req1_op,
  input  logic [4:0]  req1_cfg,
  input  logic        req1_cin,
  input  logic        req1_bin,

  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [63:0] rsp_result,
  output logic        rsp_carry,
  output logic        rsp_borrow,
  output logic        rsp_overflow,
  output logic [5:0]  rsp_comp,
  output logic        rsp_timeout,

  output logic        busy,
  output logic [1:0]  dbg_state,

  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [1:0]  alu_op_sel,
  output logic [1:0]  alu_adder_sel,
  output logic        alu_sub_sel,
  output logic        alu_mult_sel,
  output logic        alu_comp_mode,
  output logic        alu_cin,
  output logic        alu_bin,
  output logic        alu_start,

  input  logic [63:0] alu_result,
  input  logic        alu_carry_out,
  input  logic        alu_borrow_out,
  input  logic        alu_overflow,
  input  logic        alu_done,
  input  logic [5:0]  alu_comp_result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;

  logic        last_id;
  logic [15:0] wait_cnt;

  logic [31:0] lat_a;
  logic [31:0] lat_b;
  logic [1:0]  lat_op;
  logic [4:0]  lat_cfg;
  logic        lat_cin;
  logic        lat_bin;

  logic        grant_any;
  logic        grant_id;
  logic        accept;

  logic        latch_req;
  logic        cnt_clr;
  logic        cnt_inc;
  logic        capture_done;
  logic        capture_to;
  logic        rsp_fire;

  // Contention goes to the requester that was not answered last.
  always_comb begin
    grant_any = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_id;
    end else begin
      grant_id = req1_valid;
    end
  end

  assign req0_ready = (state == IDLE) && grant_any && !grant_id;
  assign req1_ready = (state == IDLE) && grant_any &&  grant_id;
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    alu_start    = 1'b0;
    rsp_valid    = 1'b0;
    latch_req    = 1'b0;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;
    capture_done = 1'b0;
    capture_to   = 1'b0;
    rsp_fire     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          latch_req = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        alu_start = 1'b1;
        cnt_clr   = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        // A done in the last permitted cycle takes priority over the timeout.
        if (alu_done) begin
          capture_done = 1'b1;
          state_nxt    = RESP;
        end else if (wait_cnt == TO_LAST) begin
          capture_to = 1'b1;
          state_nxt  = RESP;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          rsp_fire  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_id      <= 1'b1;
      wait_cnt     <= '0;
      lat_a        <= '0;
      lat_b        <= '0;
      lat_op       <= '0;
      lat_cfg      <= '0;
      lat_cin      <= 1'b0;
      lat_bin      <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_result   <= '0;
      rsp_carry    <= 1'b0;
      rsp_borrow   <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_comp     <= '0;
      rsp_timeout  <= 1'b0;
    end else begin
      if (latch_req) begin
        lat_a   <= grant_id ? req1_a   : req0_a;
        lat_b   <= grant_id ? req1_b   : req0_b;
        lat_op  <= grant_id ? req1_op  : req0_op;
        lat_cfg <= grant_id ? req1_cfg : req0_cfg;
        lat_cin <= grant_id ? req1_cin : req0_cin;
        lat_bin <= grant_id ? req1_bin : req0_bin;
        rsp_id  <= grant_id;
      end

      if (cnt_clr) begin
        wait_cnt <= '0;
      end else if (cnt_inc) begin
        wait_cnt <= wait_cnt + 16'd1;
      end

      if (capture_done) begin
        rsp_result   <= alu_result;
        rsp_carry    <= alu_carry_out;
        rsp_borrow   <= alu_borrow_out;
        rsp_overflow <= alu_overflow;
        rsp_comp     <= alu_comp_result;
        rsp_timeout  <= 1'b0;
      end else if (capture_to) begin
        rsp_result   <= '0;
        rsp_carry    <= 1'b0;
        rsp_borrow   <= 1'b0;
        rsp_overflow <= 1'b0;
        rsp_comp     <= '0;
        rsp_timeout  <= 1'b1;
      end

      if (rsp_fire) begin
        last_id <= rsp_id;
      end
    end
  end

  // ALU pins come only from the latched request, so they hold from ISSUE through RESP.
  assign alu_a         = lat_a;
  assign alu_b         = lat_b;
  assign alu_op_sel    = lat_op;
  assign alu_adder_sel = lat_cfg[4:3];
  assign alu_sub_sel   = lat_cfg[2];
  assign alu_mult_sel  = lat_cfg[1];
  assign alu_comp_mode = lat_cfg[0];
  assign alu_cin       = lat_cin;
  assign alu_bin       = lat_bin;

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter: grant order, latency, backpressure, timeout and reset abort.
// A small ALU stub answers each start after a programmable number of cycles.
module tb_alu_req_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        req0_valid = 1'b0;
  logic        req0_ready;
  logic [31:0] req0_a = '0;
  logic [31:0] req0_b = '0;
  logic [1:0]  req0_op = 2'b00;
  logic [4:0]  req0_cfg = 5'b00000;
  logic        req0_cin = 1'b0;
  logic        req0_bin = 1'b0;

  logic        req1_valid = 1'b0;
  logic        req1_ready;
  logic [31:0] req1_a = '0;
  logic [31:0] req1_b = '0;
  logic [1:0]  req1_op = 2'b01;
  logic [4:0]  req1_cfg = 5'b10110;
  logic        req1_cin = 1'b1;
  logic        req1_bin = 1'b1;

  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_id;
  logic [63:0] rsp_result;
  logic        rsp_carry;
  logic        rsp_borrow;
  logic        rsp_overflow;
  logic [5:0]  rsp_comp;
  logic        rsp_timeout;
  logic        busy;
  logic [1:0]  dbg_state;

  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [1:0]  alu_op_sel;
  logic [1:0]  alu_adder_sel;
  logic        alu_sub_sel;
  logic        alu_mult_sel;
  logic        alu_comp_mode;
  logic        alu_cin;
  logic        alu_bin;
  logic        alu_start;

  logic [63:0] alu_result;
  logic        alu_carry_out;
  logic        alu_borrow_out;
  logic        alu_overflow;
  logic        alu_done;
  logic [5:0]  alu_comp_result;

  int          n_checks = 0;
  int          n_fail = 0;

  int          stub_lat = 0;
  logic [63:0] stub_res = '0;
  logic [8:0]  stub_flags = '0;
  int          stub_cnt = 0;

  alu_req_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .req0_cfg(req0_cfg), .req0_cin(req0_cin), .req0_bin(req0_bin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .req1_cfg(req1_cfg), .req1_cin(req1_cin), .req1_bin(req1_bin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_borrow(rsp_borrow), .rsp_overflow(rsp_overflow),
    .rsp_comp(rsp_comp), .rsp_timeout(rsp_timeout), .busy(busy), .dbg_state(dbg_state),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op_sel(alu_op_sel), .alu_adder_sel(alu_adder_sel),
    .alu_sub_sel(alu_sub_sel), .alu_mult_sel(alu_mult_sel), .alu_comp_mode(alu_comp_mode),
    .alu_cin(alu_cin), .alu_bin(alu_bin), .alu_start(alu_start),
    .alu_result(alu_result), .alu_carry_out(alu_carry_out), .alu_borrow_out(alu_borrow_out),
    .alu_overflow(alu_overflow), .alu_done(alu_done), .alu_comp_result(alu_comp_result)
  );

  wire [75:0] rsp_vec  = {rsp_valid, rsp_id, rsp_timeout, rsp_result,
                          rsp_carry, rsp_borrow, rsp_overflow, rsp_comp};
  wire [72:0] pins_vec = {alu_a, alu_b, alu_op_sel, alu_adder_sel, alu_sub_sel,
                          alu_mult_sel, alu_comp_mode, alu_cin, alu_bin};
  wire [8:0]  ctl_vec  = {busy, rsp_valid, rsp_id, rsp_timeout, alu_start, dbg_state,
                          req1_ready, req0_ready};

  always #5 clk = ~clk;

  // ALU stub: done is high for one cycle, stub_lat cycles after the start cycle.
  // Outside that cycle the result/flag pins carry junk so a wrong capture shows up.
  always @(posedge clk) begin
    if (alu_start && stub_lat > 0) stub_cnt = stub_lat;
    else if (stub_cnt > 0) stub_cnt = stub_cnt - 1;
    alu_done   <= (stub_cnt == 1);
    alu_result <= (stub_cnt == 1) ? stub_res : 64'hDEAD_BEEF_0BAD_F00D;
    {alu_carry_out, alu_borrow_out, alu_overflow, alu_comp_result} <=
      (stub_cnt == 1) ? stub_flags : 9'h1ff;
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ctl"},  128'(ctl_vec),  128'd0);
    check({tag, "_rsp"},  128'(rsp_vec),  128'd0);
    check({tag, "_pins"}, 128'(pins_vec), 128'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b0;
    cyc();
    cyc();
    check_reset_state("reset");
    reset = 1'b0;
  endtask

  // One full operation, starting and ending at a negedge in IDLE.
  task automatic run_op(input logic [1:0] vmask, input logic exp_id, input int lat,
                        input int exp_k, input logic exp_to,
                        input logic [31:0] a0, input logic [31:0] b0,
                        input logic [31:0] a1, input logic [31:0] b1,
                        input logic [63:0] res, input logic [8:0] flags, input int bp);
    logic [72:0] exp_pins;
    logic [75:0] exp_rsp;
    int k;
    exp_pins = exp_id ? {a1, b1, 2'b01, 5'b10110, 1'b1, 1'b1}
                      : {a0, b0, 2'b00, 5'b00000, 1'b0, 1'b0};
    exp_rsp  = {1'b1, exp_id, exp_to, exp_to ? 64'd0 : res, exp_to ? 9'd0 : flags};
    stub_lat = lat;
    stub_res = res;
    stub_flags = flags;
    req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
    req0_valid = vmask[0];
    req1_valid = vmask[1];
    rsp_ready = (bp == 0);
    #1;
    check("grant", 128'({req1_ready, req0_ready}), exp_id ? 128'd2 : 128'd1);
    cyc();
    k = 1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("start_pulse", 128'({alu_start, busy, dbg_state}), 128'({1'b1, 1'b1, 2'd1}));
    cyc();
    k = 2;
    check("start_drop", 128'({alu_start, busy, dbg_state}), 128'({1'b0, 1'b1, 2'd2}));
    while (!rsp_valid && k < 60) begin
      cyc();
      k++;
    end
    check("latency", 128'(k), 128'(exp_k));
    check("rsp", 128'(rsp_vec), 128'(exp_rsp));
    check("pins", 128'(pins_vec), 128'(exp_pins));
    if (bp > 0) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_a = ~a0; req0_b = ~b0; req1_a = ~a1; req1_b = ~b1;
      #1;
      for (int i = 0; i < bp; i++) begin
        check("bp_ready", 128'({req1_ready, req0_ready}), 128'd0);
        check("bp_rsp", 128'(rsp_vec), 128'(exp_rsp));
        check("bp_pins", 128'(pins_vec), 128'(exp_pins));
        cyc();
      end
      rsp_ready = 1'b1;
      #1;
      check("bp_release_ready", 128'({req1_ready, req0_ready}), 128'd0);
      check("bp_release_rsp", 128'(rsp_vec), 128'(exp_rsp));
    end
    cyc();
    check("back_idle", 128'({busy, rsp_valid, dbg_state}), 128'd0);
  endtask

  initial begin
    do_reset();

    // Single request: add 5 + 7, done one cycle after start.
    run_op(2'b01, 1'b0, 1, 3, 1'b0, 32'd5, 32'd7, 32'd0, 32'd0, 64'd12, 9'h000, 0);

    // Contention from reset: 0, 1, 0, 1.
    do_reset();
    run_op(2'b11, 1'b0, 1, 3, 1'b0, 32'h11, 32'h22, 32'h33, 32'h44, 64'h33, 9'h101, 0);
    run_op(2'b11, 1'b1, 2, 4, 1'b0, 32'h55, 32'h66, 32'h77, 32'h88, 64'hFF, 9'h0a5, 0);
    run_op(2'b11, 1'b0, 1, 3, 1'b0, 32'h12345678, 32'h9, 32'hA, 32'hB,
           64'h1234_5681, 9'h040, 0);
    run_op(2'b11, 1'b1, 4, 6, 1'b0, 32'h1, 32'h2, 32'hFFFF_FFFF, 32'h1,
           64'h1_0000_0000, 9'h180, 0);

    // Backpressure: ten cycles of rsp_ready low, then the other requester wins.
    run_op(2'b01, 1'b0, 3, 5, 1'b0, 32'hCAFE_0001, 32'h2, 32'h0, 32'h0,
           64'hCAFE_0003, 9'h1ff, 10);
    run_op(2'b11, 1'b1, 1, 3, 1'b0, 32'h100, 32'h200, 32'h300, 32'h400, 64'h700, 9'h003, 0);

    // Timeout, done in the last WAIT cycle, and done one cycle too late.
    run_op(2'b01, 1'b0, 0, 18, 1'b1, 32'h9, 32'h9, 32'h0, 32'h0, 64'hABCD, 9'h1ff, 0);
    run_op(2'b01, 1'b0, 16, 18, 1'b0, 32'h10, 32'h20, 32'h0, 32'h0,
           64'h1234_5678_9ABC_DEF0, 9'h0c3, 0);
    run_op(2'b01, 1'b0, 17, 18, 1'b1, 32'h30, 32'h40, 32'h0, 32'h0, 64'h5555, 9'h1ff, 0);

    // Reset during WAIT: operation dropped, late done ignored, arbitration restarts at req0.
    stub_lat = 5;
    stub_res = 64'h7777;
    stub_flags = 9'h111;
    req0_a = 32'hAAAA_0000;
    req0_b = 32'h0000_BBBB;
    req0_valid = 1'b1;
    rsp_ready = 1'b1;
    #1;
    cyc();
    req0_valid = 1'b0;
    cyc();
    cyc();
    check("pre_reset_wait", 128'({busy, dbg_state}), 128'({1'b1, 2'd2}));
    reset = 1'b1;
    cyc();
    check_reset_state("mid_reset");
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("late_done_ignored", 128'({busy, rsp_valid, dbg_state}), 128'd0);
    end
    run_op(2'b11, 1'b0, 1, 3, 1'b0, 32'hD0, 32'hD1, 32'hE0, 32'hE1, 64'h1A1, 9'h022, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
